// File: rtl/p2s_frame_if.sv
// rtl/p2s_frame_if.sv - load/stream handshake bundle for the p2s_frame parallel-to-serial block
//
// Purpose: groups the frame-load side (d1..d8, load, load_rdy) and the serial
// output side (q, q_valid, q_ready, optional q_last) of p2s_frame.
// Optional feature macro: P2S_LAST_EN adds q_last.
//
// Signals (W = 2**N bits per word):
//   d1..d8    W  parallel frame, d1 newest (MSB word), d8 oldest (LSB word)
//   load      1  frame-valid strobe, sampled with load_rdy
//   load_rdy  1  block can accept a frame this cycle
//   q         W  serial output word
//   q_valid   1  q holds a valid word
//   q_ready   1  downstream accepts q
//   q_last    1  last beat of a frame (P2S_LAST_EN only)
// Modports: master = frame producer / word consumer, slave = p2s_frame.

interface p2s_frame_if #(
  parameter int N = 4
);
  localparam int W = 2 ** N;

  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [W-1:0] d4;
  logic [W-1:0] d5;
  logic [W-1:0] d6;
  logic [W-1:0] d7;
  logic [W-1:0] d8;
  logic         load;
  logic         load_rdy;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
`ifdef P2S_LAST_EN
  logic         q_last;
`endif

`ifdef P2S_LAST_EN
  modport master (
    output d1, d2, d3, d4, d5, d6, d7, d8, load, q_ready,
    input  load_rdy, q, q_valid, q_last
  );
  modport slave (
    input  d1, d2, d3, d4, d5, d6, d7, d8, load, q_ready,
    output load_rdy, q, q_valid, q_last
  );
`else
  modport master (
    output d1, d2, d3, d4, d5, d6, d7, d8, load, q_ready,
    input  load_rdy, q, q_valid
  );
  modport slave (
    input  d1, d2, d3, d4, d5, d6, d7, d8, load, q_ready,
    output load_rdy, q, q_valid
  );
`endif
endinterface

// File: rtl/p2s_frame.sv
// rtl/p2s_frame.sv - eight-word frame to serial word stream converter
//
// Purpose: captures an 8-word frame in one cycle and emits it one word per
// accepted beat, oldest word (d8) first, newest (d1) last. A new frame may be
// loaded in the same cycle as the final beat for gap-free streaming.
// Optional feature macro: P2S_LAST_EN drives q_last = q_valid & (cnt == 7).
//
// Ports:
//   clk    1  clock, rising edge
//   rst_n  1  asynchronous active-low reset
//   bus    p2s_frame_if.slave (d1..d8, load, load_rdy, q, q_valid, q_ready[, q_last])

module p2s_frame #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  p2s_frame_if.slave  bus
);
  localparam int W = 2 ** N;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [2:0]   r_cnt;
  logic [W-1:0] r_frame [8];   // index 0 holds d8 (first out), index 7 holds d1

  logic         w_accept;
  logic         w_beat;
  logic         w_cnt_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    w_cnt_last   = (r_cnt == 3'd7);
    bus.q_valid  = 1'b0;
    bus.load_rdy = 1'b0;
    bus.q        = r_frame[r_cnt];
    w_beat       = 1'b0;
    w_accept     = 1'b0;

    case (r_state)
      IDLE: begin
        bus.load_rdy = 1'b1;
        w_accept     = bus.load;
        if (w_accept) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        bus.q_valid  = 1'b1;
        w_beat       = bus.q_ready;
        // The slot frees up only as the final word leaves, so a reload can
        // overlap that beat without losing or repeating a word.
        bus.load_rdy = w_cnt_last & bus.q_ready;
        w_accept     = bus.load & bus.load_rdy;
        if (w_beat && w_cnt_last && !w_accept) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

`ifdef P2S_LAST_EN
  assign bus.q_last = bus.q_valid & w_cnt_last;
`endif

  // Beat counter and frame register. Clearing the frame on reset makes q
  // read 0 immediately while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        r_frame[i] <= '0;
      end
    end else if (w_accept) begin
      r_cnt      <= 3'd0;
      r_frame[0] <= bus.d8;
      r_frame[1] <= bus.d7;
      r_frame[2] <= bus.d6;
      r_frame[3] <= bus.d5;
      r_frame[4] <= bus.d4;
      r_frame[5] <= bus.d3;
      r_frame[6] <= bus.d2;
      r_frame[7] <= bus.d1;
    end else if (w_beat) begin
      // Wraps 7 -> 0 on the final beat, leaving cnt = 0 in IDLE.
      r_cnt <= r_cnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_p2s_frame.sv
// tb/tb_p2s_frame.sv - directed self-checking bench for p2s_frame

module tb_p2s_frame;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  p2s_frame_if #(.N(4)) bus ();

  p2s_frame #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // d8..d1 = base+8 .. base+1
  task automatic set_frame(input logic [15:0] base);
    bus.d1 = base + 16'd1;
    bus.d2 = base + 16'd2;
    bus.d3 = base + 16'd3;
    bus.d4 = base + 16'd4;
    bus.d5 = base + 16'd5;
    bus.d6 = base + 16'd6;
    bus.d7 = base + 16'd7;
    bus.d8 = base + 16'd8;
  endtask

  task automatic check_beat(input string tag, input logic [15:0] exp_q, input logic exp_last);
    check({tag, "_q"}, {16'd0, bus.q}, {16'd0, exp_q});
    check({tag, "_valid"}, {31'd0, bus.q_valid}, 32'd1);
`ifdef P2S_LAST_EN
    check({tag, "_last"}, {31'd0, bus.q_last}, {31'd0, exp_last});
`else
    if (exp_last) begin
      check({tag, "_rdy_at_last"}, {31'd0, bus.load_rdy}, {31'd0, bus.q_ready});
    end
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, bus.q_valid}, 32'd0);
    check({tag, "_rdy"}, {31'd0, bus.load_rdy}, 32'd1);
  endtask

  task automatic load_frame(input logic [15:0] base);
    set_frame(base);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.load    = 1'b0;
    bus.q_ready = 1'b1;
    set_frame(16'h0000);

    // Reset state
    #2;
    check("rst_valid", {31'd0, bus.q_valid}, 32'd0);
    check("rst_q", {16'd0, bus.q}, 32'd0);
    check("rst_rdy", {31'd0, bus.load_rdy}, 32'd1);
`ifdef P2S_LAST_EN
    check("rst_last", {31'd0, bus.q_last}, 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Single frame 8..1, first word on the cycle after the load edge
    load_frame(16'h0000);
    for (int i = 0; i < 8; i++) begin
      check_beat("single", 16'(8 - i), i == 7);
      check("single_rdy", {31'd0, bus.load_rdy}, {31'd0, i == 7});
      tick();
    end
    check_idle("single_end");

    // Backpressure at cnt = 2; d inputs scrambled while busy
    load_frame(16'h0000);
    check_beat("bp_0", 16'h0008, 1'b0);
    tick();
    check_beat("bp_1", 16'h0007, 1'b0);
    tick();
    bus.q_ready = 1'b0;
    set_frame(16'hFF00);
    for (int i = 0; i < 3; i++) begin
      check_beat("bp_hold", 16'h0006, 1'b0);
      check("bp_hold_rdy", {31'd0, bus.load_rdy}, 32'd0);
      tick();
    end
    bus.q_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_beat("bp_resume", 16'(6 - i), i == 5);
      tick();
    end
    check_idle("bp_end");

    // Back-to-back frames: 16 consecutive valid beats
    load_frame(16'h0000);
    for (int i = 0; i < 8; i++) begin
      check_beat("b2b_a", 16'(8 - i), i == 7);
      if (i == 7) begin
        set_frame(16'h00A0);
        bus.load = 1'b1;
      end
      tick();
    end
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_beat("b2b_b", 16'(16'h00A8 - 16'(i)), i == 7);
      tick();
    end
    check_idle("b2b_end");

    // Busy load at cnt = 3 with q_ready = 0 is ignored
    load_frame(16'h0000);
    for (int i = 0; i < 3; i++) begin
      check_beat("busy_pre", 16'(8 - i), 1'b0);
      tick();
    end
    bus.q_ready = 1'b0;
    set_frame(16'h5500);
    bus.load = 1'b1;
    check("busy_rdy", {31'd0, bus.load_rdy}, 32'd0);
    tick();
    bus.load = 1'b0;
    bus.q_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_beat("busy_post", 16'(5 - i), i == 4);
      tick();
    end
    check_idle("busy_end");

    // Reset mid-frame at cnt = 4: outputs clear without a clock edge
    load_frame(16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check_beat("mrst_pre", 16'h0004, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, bus.q_valid}, 32'd0);
    check("mrst_q", {16'd0, bus.q}, 32'd0);
    check("mrst_rdy", {31'd0, bus.load_rdy}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("mrst_wait");
    load_frame(16'h00C0);
    for (int i = 0; i < 8; i++) begin
      check_beat("mrst_new", 16'(16'h00C8 - 16'(i)), i == 7);
      tick();
    end
    check_idle("mrst_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/p2s_frame.md
P2S_FRAME -- requirements
Module: p2s_frame

Interface
REQ-001 Parameter N, default 4; word width is 2**N bits (16 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d1..d8  input  2**N each  parallel frame from the serial-to-parallel stage; d1 = newest word (MSB), d8 = oldest word (LSB).
REQ-005 load  input  1  frame-valid strobe; d1..d8 are sampled when load and load_rdy are both 1.
REQ-006 load_rdy  output  1  block can accept a frame this cycle.
REQ-007 q  output  2**N  serial output word.
REQ-008 q_valid  output  1  q holds a valid word.
REQ-009 q_ready  input  1  downstream accepts q; a beat transfers when q_valid and q_ready are both 1.
REQ-010 q_last  output  1  present only when P2S_LAST_EN is defined (see Configuration).

Function
REQ-011 The block shall capture all eight words into an internal 8 x 2**N frame register on an accepted load, in a single cycle.
REQ-012 Emission order shall be d8, d7, ..., d1, which restores original arrival order.
REQ-013 The FSM shall have two states: IDLE and SEND.
REQ-014 IDLE -> SEND on an accepted load.
REQ-015 SEND -> IDLE when the 8th beat transfers and no load is accepted in the same cycle.
REQ-016 A 3-bit beat counter cnt shall be 0 on entry to SEND, increment on each transferred beat, and identify the last beat at cnt == 7.
REQ-017 q shall equal the frame word selected by cnt (cnt 0 -> d8 ... cnt 7 -> d1).
REQ-018 q_valid shall be 1 in SEND and 0 in IDLE.
REQ-019 Latency: the first word shall appear with q_valid = 1 in the cycle after the accepting load edge.
REQ-020 load_rdy = (state == IDLE) OR (state == SEND AND cnt == 7 AND q_ready).
REQ-021 Back-to-back: a load accepted in the same cycle as the last beat transfers shall reload the frame, reset cnt to 0, and stay in SEND with no idle gap.
REQ-022 While q_valid = 1 and q_ready = 0, q, cnt and the frame register shall hold unchanged.
REQ-023 A load asserted while load_rdy = 0 shall be ignored; no state shall change.
REQ-024 Changes on d1..d8 outside an accepted load shall not affect q.

Reset
REQ-025 On rst_n = 0, asynchronously:
  - state = IDLE, cnt = 0, frame register = 0
  - q = 0, q_valid = 0, load_rdy = 1
  - q_last = 0, when present
REQ-026 Reset asserted mid-frame shall discard the remaining words; after release the block shall wait in IDLE for a new load.
REQ-027 The first load is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro P2S_LAST_EN: when defined, output q_last shall exist and equal q_valid AND (cnt == 7).
REQ-029 When P2S_LAST_EN is undefined, the q_last port and its logic shall be absent; all other behaviour is identical.

Verification
REQ-030 Single frame: load with d8..d1 = 0x0008..0x0001, q_ready held 1 -> q = 0x0008, 0x0007, ..., 0x0001 on 8 consecutive cycles starting 1 cycle after load; q_valid then drops to 0.
REQ-031 Backpressure: q_ready = 0 for 3 cycles at cnt = 2 -> q holds 0x0006 with q_valid = 1 for those cycles; sequence resumes with no loss or duplication.
REQ-032 Back-to-back: second frame of 0x00A8..0x00A1 loaded in the last-beat cycle -> 0x0001 is followed immediately by 0x00A8; 16 consecutive valid beats in total.
REQ-033 Busy load: load pulsed at cnt = 3 with q_ready = 0 -> ignored; the original frame completes unchanged.
REQ-034 Reset mid-frame: rst_n = 0 at cnt = 4 -> q_valid = 0 and q = 0 immediately, without waiting for a clock edge; after release load_rdy = 1 and the next frame starts at its own d8.
REQ-035 With P2S_LAST_EN: q_last = 1 only on the 0x0001 beat of REQ-030; without the macro, the port is absent and elaboration succeeds.
